// File: rtl/ekf_pkg.sv
// Shared definitions for the EKF-SLAM accelerator: stage codes, scheduler
// FSM states and the fixed-point formats used by the operand words.
package ekf_pkg;

   // Q1.12.19 data words (vlr, rk) and angle fraction width
   localparam int DATA_INT_BIT  = 12;
   localparam int DATA_DEC_BIT  = 19;
   localparam int ANGLE_DEC_BIT = 15;

   // Stage command / completion codes carried on stage_val and stage_rdy
   typedef enum logic [2:0] {
      STG_IDLE  = 3'd0,
      STG_PRD   = 3'd1,
      STG_NEW   = 3'd2,
      STG_UPD   = 3'd3,
      STG_ASSOC = 3'd4
   } stage_t;

   // Scheduler FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fsm_t;

   // True for the four codes that start a stage; 0 and 5-7 are ignored
   function automatic logic is_stage_cmd(input logic [2:0] code);
      return (code >= 3'd1) && (code <= 3'd4);
   endfunction

endpackage

// File: rtl/stage_latency_calc.sv
// Combinational stage duration: N cycles from stage code, map size and
// landmark index. Degenerate commands collapse to a 1-cycle no-op and the
// result saturates to all-ones if it does not fit the run counter.
module stage_latency_calc
   import ekf_pkg::*;
#(
   parameter int ROW_LEN  = 10,
   parameter int CNT_W    = 16,
   parameter int PRD_LAT  = 64,
   parameter int NEW_LAT  = 48,
   parameter int UPD_BASE = 32,
   parameter int UPD_LM   = 8,
   parameter int ASSOC_LM = 16
) (
   input  logic [2:0]         stage_code,
   input  logic [ROW_LEN-1:0] landmark_num,
   input  logic [ROW_LEN-1:0] l_k,
   output logic [CNT_W-1:0]   n_cycles
);

   // Intermediate width is wide enough that no product wraps before saturation
   localparam int WIDE_W = 32;
   localparam logic [WIDE_W-1:0] CNT_MAX = {{(WIDE_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

   logic [WIDE_W-1:0] lm_w_s;
   logic [WIDE_W-1:0] lk_w_s;
   logic [WIDE_W-1:0] raw_s;

   // Raw duration per stage, including the no-op cases for bad landmark indices
   always_comb begin
      lm_w_s = WIDE_W'(landmark_num);
      lk_w_s = WIDE_W'(l_k);
      raw_s  = 32'd1;
      case (stage_code)
         STG_PRD: begin
            raw_s = 32'(PRD_LAT);
         end
         STG_NEW: begin
            // NEW must append exactly one slot past the current map
            if (lk_w_s == (lm_w_s + 32'd1)) begin
               raw_s = 32'(NEW_LAT);
            end else begin
               raw_s = 32'd1;
            end
         end
         STG_UPD: begin
            // UPD needs a landmark that already exists (1-based)
            if ((lk_w_s == 32'd0) || (lk_w_s > lm_w_s)) begin
               raw_s = 32'd1;
            end else begin
               raw_s = 32'(UPD_BASE) + (32'(UPD_LM) * lm_w_s);
            end
         end
         STG_ASSOC: begin
            raw_s = 32'(ASSOC_LM) * lm_w_s;
         end
         default: begin
            raw_s = 32'd1;
         end
      endcase
   end

   // Saturate to counter range and clamp to at least one cycle
   always_comb begin
      if (raw_s > CNT_MAX) begin
         n_cycles = {CNT_W{1'b1}};
      end else if (raw_s == 32'd0) begin
         n_cycles = {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         n_cycles = raw_s[CNT_W-1:0];
      end
   end

endmodule

// File: rtl/ekf_slam_stage_ctrl.sv
// EKF-SLAM stage scheduler: accepts one stage command while idle, holds its
// operands, counts out the stage duration and pulses stage_rdy with the code.
module ekf_slam_stage_ctrl
   import ekf_pkg::*;
#(
   parameter int RSA_DW   = 1 + DATA_INT_BIT + DATA_DEC_BIT,
   parameter int RSA_AW   = 17,
   parameter int ROW_LEN  = 10,
   parameter int PRD_LAT  = 64,
   parameter int NEW_LAT  = 48,
   parameter int UPD_BASE = 32,
   parameter int UPD_LM   = 8,
   parameter int ASSOC_LM = 16,
   parameter int CNT_W    = 16
) (
   input  logic               clk,
   input  logic               sys_rst,
   input  logic [2:0]         stage_val,
   input  logic [ROW_LEN-1:0] landmark_num,
   input  logic [ROW_LEN-1:0] l_k,
   input  logic [RSA_DW-1:0]  vlr,
   input  logic [RSA_AW-1:0]  alpha,
   input  logic [RSA_DW-1:0]  rk,
   input  logic [RSA_AW-1:0]  phi,
   output logic [2:0]         stage_rdy
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   fsm_t               state_r;
   fsm_t               state_nxt_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [CNT_W-1:0]   cnt_nxt_s;
   logic [2:0]         code_r;
   logic [2:0]         code_nxt_s;
   logic [2:0]         rdy_nxt_s;
   logic               accept_s;
   logic [CNT_W-1:0]   n_s;

   logic [ROW_LEN-1:0] lm_r;
   logic [ROW_LEN-1:0] lk_r;
   logic [RSA_DW-1:0]  vlr_r;
   logic [RSA_AW-1:0]  alpha_r;
   logic [RSA_DW-1:0]  rk_r;
   logic [RSA_AW-1:0]  phi_r;
   logic               datapath_unused_s;

   // Duration is computed from the live inputs in the accepting cycle,
   // which are exactly the values captured into the operand registers.
   stage_latency_calc #(
      .ROW_LEN  (ROW_LEN),
      .CNT_W    (CNT_W),
      .PRD_LAT  (PRD_LAT),
      .NEW_LAT  (NEW_LAT),
      .UPD_BASE (UPD_BASE),
      .UPD_LM   (UPD_LM),
      .ASSOC_LM (ASSOC_LM)
   ) u_latency (
      .stage_code   (stage_val),
      .landmark_num (landmark_num),
      .l_k          (l_k),
      .n_cycles     (n_s)
   );

   // Next-state, counter and completion-pulse logic
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      code_nxt_s  = code_r;
      rdy_nxt_s   = 3'd0;
      accept_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (is_stage_cmd(stage_val)) begin
               accept_s    = 1'b1;
               state_nxt_s = ST_RUN;
               cnt_nxt_s   = n_s - CNT_ONE;
               code_nxt_s  = stage_val;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Last RUN cycle: register the code so stage_rdy is high in DONE
            if (cnt_r == {CNT_W{1'b0}}) begin
               state_nxt_s = ST_DONE;
               rdy_nxt_s   = code_r;
            end else begin
               cnt_nxt_s   = cnt_r - CNT_ONE;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM state, run counter, stage code and registered completion output
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         code_r    <= 3'd0;
         stage_rdy <= 3'd0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         code_r    <= code_nxt_s;
         stage_rdy <= rdy_nxt_s;
      end
   end

   // Operand capture on command acceptance; held stable for the whole stage
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         lm_r    <= {ROW_LEN{1'b0}};
         lk_r    <= {ROW_LEN{1'b0}};
         vlr_r   <= {RSA_DW{1'b0}};
         alpha_r <= {RSA_AW{1'b0}};
         rk_r    <= {RSA_DW{1'b0}};
         phi_r   <= {RSA_AW{1'b0}};
      end else if (accept_s) begin
         lm_r    <= landmark_num;
         lk_r    <= l_k;
         vlr_r   <= vlr;
         alpha_r <= alpha;
         rk_r    <= rk;
         phi_r   <= phi;
      end else begin
         lm_r    <= lm_r;
         lk_r    <= lk_r;
         vlr_r   <= vlr_r;
         alpha_r <= alpha_r;
         rk_r    <= rk_r;
         phi_r   <= phi_r;
      end
   end

   // Operand registers are consumed by the systolic datapath outside this block
   assign datapath_unused_s = ^{lm_r, lk_r, vlr_r, alpha_r, rk_r, phi_r};

endmodule

// File: tb/tb_ekf_slam_stage_ctrl.sv
// Self-checking bench for ekf_slam_stage_ctrl: a vector table of commands with
// hand-computed durations, plus hand sequences for reset and mid-run changes.
// Expected pulses go into a scoreboard queue and are popped when stage_rdy fires.
module tb_ekf_slam_stage_ctrl;

   localparam int RSA_DW  = 32;
   localparam int RSA_AW  = 17;
   localparam int ROW_LEN = 10;

   logic               clk = 1'b0;
   logic               sys_rst;
   logic [2:0]         stage_val;
   logic [ROW_LEN-1:0] landmark_num;
   logic [ROW_LEN-1:0] l_k;
   logic [RSA_DW-1:0]  vlr;
   logic [RSA_AW-1:0]  alpha;
   logic [RSA_DW-1:0]  rk;
   logic [RSA_AW-1:0]  phi;
   logic [2:0]         stage_rdy;

   always #5 clk = ~clk;

   ekf_slam_stage_ctrl dut (
      .clk          (clk),
      .sys_rst      (sys_rst),
      .stage_val    (stage_val),
      .landmark_num (landmark_num),
      .l_k          (l_k),
      .vlr          (vlr),
      .alpha        (alpha),
      .rk           (rk),
      .phi          (phi),
      .stage_rdy    (stage_rdy)
   );

   typedef struct {
      logic [2:0] sv;
      int         lm;
      int         lk;
      int         hold;
      logic [2:0] exp_code;   // 0: command must be ignored
      int         exp_n;
   } vec_t;

   typedef struct {
      logic [2:0] code;
      int         edge_no;
   } exp_t;

   vec_t vecs [0:12];
   exp_t sb_q [$];

   int checks      = 0;
   int errors      = 0;
   int edge_cnt    = 0;
   int pulses_seen = 0;

   // Monitor: count rising edges, sample 1 time unit later, match pulses
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         edge_cnt = edge_cnt + 1;
         #1;
         if (stage_rdy !== 3'd0) begin
            pulses_seen = pulses_seen + 1;
            checks = checks + 1;
            if (sb_q.size() == 0) begin
               errors = errors + 1;
               $display("FAIL unexpected_pulse: got stage_rdy=%0d at edge %0d, want 0", stage_rdy, edge_cnt);
            end else begin
               e = sb_q.pop_front();
               if (stage_rdy !== e.code) begin
                  errors = errors + 1;
                  $display("FAIL pulse_code: got %0d want %0d (edge %0d)", stage_rdy, e.code, edge_cnt);
               end
               checks = checks + 1;
               if (edge_cnt != e.edge_no) begin
                  errors = errors + 1;
                  $display("FAIL pulse_edge: got edge %0d want edge %0d (code %0d)", edge_cnt, e.edge_no, e.code);
               end
            end
         end
      end
   end

   task automatic wait_drain(input int limit);
      int t;
      t = 0;
      while ((sb_q.size() != 0) && (t < limit)) begin
         @(negedge clk);
         t = t + 1;
      end
      if (sb_q.size() != 0) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL timeout: got %0d pending pulses after %0d cycles, want 0", sb_q.size(), limit);
         sb_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_no_pulse(input string name, input int p0);
      checks = checks + 1;
      if (pulses_seen != p0) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d pulses, want 0", name, pulses_seen - p0);
      end
   endtask

   // Drive one command at a falling edge; the next rising edge is edge k
   task automatic run_cmd(input logic [2:0] sv, input int lm, input int lk,
                          input int hold, input logic [2:0] exp_code, input int exp_n);
      int   p0;
      exp_t e;
      p0 = pulses_seen;
      @(negedge clk);
      stage_val    = sv;
      landmark_num = ROW_LEN'(lm);
      l_k          = ROW_LEN'(lk);
      if (exp_code != 3'd0) begin
         e.code    = exp_code;
         e.edge_no = edge_cnt + 1 + exp_n;
         sb_q.push_back(e);
      end
      repeat (hold) @(negedge clk);
      stage_val = 3'd0;
      if (exp_code != 3'd0) begin
         wait_drain(exp_n + 50);
      end else begin
         repeat (100) @(negedge clk);
         check_no_pulse("ignored_cmd", p0);
      end
   endtask

   initial begin
      int   p0;
      exp_t e;

      //           sv    lm    lk  hold code  N
      vecs[0]  = '{3'd4,    4,    0, 2, 3'd4,    64};  // ASSOC held 2 cycles
      vecs[1]  = '{3'd1,    0,    0, 1, 3'd1,    64};  // PRD
      vecs[2]  = '{3'd3,    4,    2, 1, 3'd3,    64};  // UPD valid
      vecs[3]  = '{3'd3,    4,    5, 1, 3'd3,     1};  // UPD l_k past map
      vecs[4]  = '{3'd2,    4,    5, 1, 3'd2,    48};  // NEW append
      vecs[5]  = '{3'd2,    4,    3, 1, 3'd2,     1};  // NEW wrong slot
      vecs[6]  = '{3'd4,    0,    0, 1, 3'd4,     1};  // ASSOC empty map
      vecs[7]  = '{3'd3,    4,    0, 1, 3'd3,     1};  // UPD l_k=0
      vecs[8]  = '{3'd5,    4,    1, 1, 3'd0,     0};  // ignored code
      vecs[9]  = '{3'd7,    4,    1, 1, 3'd0,     0};  // ignored code
      vecs[10] = '{3'd2,    0,    1, 1, 3'd2,    48};  // NEW into empty map
      vecs[11] = '{3'd3, 1023,    1, 1, 3'd3,  8216};  // UPD largest map
      vecs[12] = '{3'd4, 1023,    0, 1, 3'd4, 16368};  // ASSOC largest map

      sys_rst      = 1'b1;
      stage_val    = 3'd0;
      landmark_num = '0;
      l_k          = '0;
      vlr          = 32'd2 << 19;
      alpha        = RSA_AW'(32'd1 << 17);
      rk           = 32'd5 << 19;
      phi          = 17'd100;
      repeat (3) @(negedge clk);
      sys_rst = 1'b0;
      @(negedge clk);
      checks = checks + 1;
      if (stage_rdy !== 3'd0) begin
         errors = errors + 1;
         $display("FAIL reset_rdy: got %0d want 0", stage_rdy);
      end

      // Reset pulse while idle
      repeat (2) @(negedge clk);
      sys_rst = 1'b1;
      @(negedge clk);
      sys_rst = 1'b0;
      checks = checks + 1;
      if (stage_rdy !== 3'd0) begin
         errors = errors + 1;
         $display("FAIL idle_reset_rdy: got %0d want 0", stage_rdy);
      end
      @(negedge clk);

      for (int i = 0; i <= 12; i++) begin
         run_cmd(vecs[i].sv, vecs[i].lm, vecs[i].lk, vecs[i].hold,
                 vecs[i].exp_code, vecs[i].exp_n);
      end

      // ASSOC with 4 landmarks; map size and command change mid-run
      @(negedge clk);
      stage_val    = 3'd4;
      landmark_num = 10'd4;
      e.code       = 3'd4;
      e.edge_no    = edge_cnt + 1 + 64;
      sb_q.push_back(e);
      @(negedge clk);
      stage_val = 3'd0;
      repeat (10) @(negedge clk);
      landmark_num = 10'd9;
      l_k          = 10'd3;
      stage_val    = 3'd1;
      @(negedge clk);
      stage_val = 3'd0;
      wait_drain(200);

      // PRD interrupted by reset at cycle 20 must never complete
      p0 = pulses_seen;
      @(negedge clk);
      stage_val = 3'd1;
      @(negedge clk);
      stage_val = 3'd0;
      repeat (19) @(negedge clk);
      sys_rst = 1'b1;
      repeat (2) @(negedge clk);
      sys_rst = 1'b0;
      repeat (100) @(negedge clk);
      check_no_pulse("reset_mid_prd", p0);

      // Normal PRD right after the reset
      run_cmd(3'd1, 4, 0, 1, 3'd1, 64);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
